// File: rtl/mmio_bus_ctrl_pkg.sv
// mmio_bus_ctrl_pkg: address map, read-select encoding and timer control bits for the MMIO controller.
package mmio_bus_ctrl_pkg;
    localparam logic [3:0] LED_BASE   = 4'h8;
    localparam logic [3:0] SW_BASE    = 4'h9;
    localparam logic [7:0] TMR_LOAD   = 8'hA0;
    localparam logic [7:0] TMR_CTRL   = 8'hA1;
    localparam logic [7:0] TMR_COUNT  = 8'hA2;
    localparam logic [7:0] TMR_STATUS = 8'hA3;
    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;

    typedef enum logic [2:0] {SEL_MEM, SEL_LED, SEL_SW, SEL_TMR, SEL_ZERO} rd_sel_e;
    typedef enum logic {T_IDLE, T_RUN} tmr_state_e;

    function automatic rd_sel_e decode(input logic [7:0] a);
        return !a[7]                   ? SEL_MEM :
               a[7:4] == LED_BASE      ? SEL_LED :
               a[7:4] == SW_BASE       ? SEL_SW  :
               a[7:2] == TMR_LOAD[7:2] ? SEL_TMR : SEL_ZERO;
    endfunction
endpackage

// File: rtl/mmio_bus_ctrl_timer.sv
// mmio_bus_ctrl_timer: prescaled down-counter with enable/autoreload control and sticky W1C expiry flag.
module mmio_bus_ctrl_timer
    import mmio_bus_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int PS_W     = 16
) (
    input  logic        clk_50MHz,
    input  logic        reset_n,
    input  logic        i_wr_load,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_status,
    input  logic [15:0] i_wdata,
    input  logic [7:0]  i_rd_addr,
    output logic [15:0] o_rdata,
    output logic        o_expired
);
    logic [15:0]     r_load, r_count;
    logic [PS_W-1:0] r_ps;
    logic            r_ar, r_expired;
    tmr_state_e      r_state;
    logic            w_tick, w_expire;

    assign w_tick   = r_state == T_RUN && r_ps == PS_W'(PRESCALE - 1);
    // A zero count expires on the first tick just like a count of one.
    assign w_expire = w_tick && r_count <= 16'd1;

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_load    <= '0;
            r_count   <= '0;
            r_ps      <= '0;
            r_ar      <= 1'b0;
            r_expired <= 1'b0;
            r_state   <= T_IDLE;
        end else begin
            r_ps    <= (i_wr_load || w_tick || r_state == T_IDLE) ? '0 : r_ps + 1'b1;
            r_count <= i_wr_load ? i_wdata :
                       !w_tick ? r_count :
                       r_count > 16'd1 ? r_count - 16'd1 :
                       r_ar ? r_load : '0;
            if (i_wr_load)
                r_load <= i_wdata;
            if (i_wr_ctrl) begin
                r_state <= i_wdata[CTRL_EN] ? T_RUN : T_IDLE;
                r_ar    <= i_wdata[CTRL_AR];
            end else if (w_expire && !r_ar)
                r_state <= T_IDLE;
            r_expired <= w_expire || (r_expired && !(i_wr_status && i_wdata[0]));
        end
    end

    assign o_rdata = i_rd_addr == TMR_LOAD  ? r_load :
                     i_rd_addr == TMR_CTRL  ? {14'd0, r_ar, r_state == T_RUN} :
                     i_rd_addr == TMR_COUNT ? r_count : {15'd0, r_expired};
    assign o_expired = r_expired;
endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: address decode, memory write gating, LED/switch registers and one-cycle read mux.
// Define MMIO_TIMER_EN to include the timer at 0xA0-0xA3; otherwise those addresses read 0.
module mmio_bus_ctrl
    import mmio_bus_ctrl_pkg::*;
#(
    parameter int LED_W    = 10,
    parameter int SW_W     = 10,
    parameter int PRESCALE = 50000,
    parameter int PS_W     = 16
) (
    input  logic             clk_50MHz,
    input  logic             reset_n,
    input  logic [7:0]       addr,
    input  logic [15:0]      wdata,
    input  logic             w_en,
    input  logic [15:0]      mem_q,
    output logic             mem_wren,
    output logic [15:0]      din,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             tmr_expired
);
    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sw_meta, r_sw_sync;
    rd_sel_e          r_rd_sel, w_sel;
    logic [15:0]      r_rdata, w_rdata, w_tmr_rdata;
    logic             w_wr_periph;

    assign w_sel       = decode(addr);
    assign mem_wren    = w_en & ~addr[7];
    assign w_wr_periph = w_en & addr[7];

`ifdef MMIO_TIMER_EN
    mmio_bus_ctrl_timer #(
        .PRESCALE(PRESCALE),
        .PS_W    (PS_W)
    ) u_timer (
        .clk_50MHz  (clk_50MHz),
        .reset_n    (reset_n),
        .i_wr_load  (w_wr_periph && addr == TMR_LOAD),
        .i_wr_ctrl  (w_wr_periph && addr == TMR_CTRL),
        .i_wr_status(w_wr_periph && addr == TMR_STATUS),
        .i_wdata    (wdata),
        .i_rd_addr  (addr),
        .o_rdata    (w_tmr_rdata),
        .o_expired  (tmr_expired)
    );
`else
    logic w_unused;
    assign w_unused    = &{1'b0, wdata, PRESCALE[0], PS_W[0]};
    assign w_tmr_rdata = 16'h0000;
    assign tmr_expired = 1'b0;
`endif

    assign w_rdata = w_sel == SEL_LED ? 16'(r_led) :
                     w_sel == SEL_SW  ? 16'(r_sw_sync) :
                     w_sel == SEL_TMR ? w_tmr_rdata : 16'h0000;

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_rd_sel  <= SEL_MEM;
            r_rdata   <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            r_rd_sel  <= w_sel;
            r_rdata   <= w_rdata;
            if (w_wr_periph && w_sel == SEL_LED)
                r_led <= wdata[LED_W-1:0];
        end
    end

    // Memory reads pass straight through so their latency matches the synchronous RAM.
    assign din = r_rd_sel == SEL_MEM ? mem_q : r_rdata;
    assign led = r_led;
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: randomized and directed stimulus scored against a behavioural model of the MMIO map.
module tb_mmio_bus_ctrl;
    localparam int P = 4;

    logic        clk = 1'b0, rst_n = 1'b0, w_en = 1'b0, mem_wren, exp_o;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0, mem_q = '0, din;
    logic [9:0]  sw = '0, led;

    always #5 clk = ~clk;

    mmio_bus_ctrl #(.LED_W(10), .SW_W(10), .PRESCALE(P), .PS_W(3)) dut (
        .clk_50MHz  (clk),
        .reset_n    (rst_n),
        .addr       (addr),
        .wdata      (wdata),
        .w_en       (w_en),
        .mem_q      (mem_q),
        .mem_wren   (mem_wren),
        .din        (din),
        .sw         (sw),
        .led        (led),
        .tmr_expired(exp_o)
    );

    typedef struct packed {
        int          edge_n;
        logic        is_mem;
        logic [15:0] data;
        logic [9:0]  led;
        logic        expd;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0, errors = 0, edge_cnt = 0, e0;

    logic [9:0] m_led, m_sw1, m_sw2;
    logic       m_exp;
`ifdef MMIO_TIMER_EN
    logic [15:0] m_load, m_count;
    int          m_ps;
    logic        m_en, m_ar;
`endif

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_led = '0; m_sw1 = '0; m_sw2 = '0; m_exp = 1'b0;
`ifdef MMIO_TIMER_EN
        m_load = '0; m_count = '0; m_ps = 0; m_en = 1'b0; m_ar = 1'b0;
`endif
    endtask

    // Drive one cycle of inputs and predict what the next clock edge produces.
    task automatic step(input logic [7:0] a, input logic [15:0] d, input logic we, input logic [9:0] s);
        exp_t        e;
        logic [15:0] rd;
`ifdef MMIO_TIMER_EN
        logic tick, ev, wl, wc, ws;
`endif
        @(posedge clk);
        #1;
        addr = a; wdata = d; w_en = we; sw = s; mem_q = 16'($urandom);
        rd = (a[7:4] == 4'h8) ? {6'd0, m_led} : (a[7:4] == 4'h9) ? {6'd0, m_sw2} : 16'h0;
`ifdef MMIO_TIMER_EN
        case (a)
            8'hA0:   rd = m_load;
            8'hA1:   rd = {14'd0, m_ar, m_en};
            8'hA2:   rd = m_count;
            8'hA3:   rd = {15'd0, m_exp};
            default: ;
        endcase
        wl = we && a == 8'hA0;
        wc = we && a == 8'hA1;
        ws = we && a == 8'hA3;
        tick = m_en && m_ps == P - 1;
        ev = tick && m_count <= 1;
        m_ps = (!m_en || tick || wl) ? 0 : m_ps + 1;
        if (wl) m_count = d;
        else if (tick) m_count = (m_count > 1) ? m_count - 16'd1 : (m_ar ? m_load : 16'd0);
        if (wl) m_load = d;
        if (wc) begin
            m_en = d[0];
            m_ar = d[1];
        end else if (ev && !m_ar) m_en = 1'b0;
        m_exp = ev || (m_exp && !(ws && d[0]));
`endif
        if (we && a[7:4] == 4'h8) m_led = d[9:0];
        m_sw2 = m_sw1;
        m_sw1 = s;
        e.edge_n = edge_cnt + 1;
        e.is_mem = !a[7];
        e.data = rd;
        e.led = m_led;
        e.expd = m_exp;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("mem_wren", {31'd0, mem_wren}, {31'd0, w_en & ~addr[7]});
            if (q.size() != 0 && q[0].edge_n == edge_cnt) begin
                mon_e = q.pop_front();
                check("din", {16'd0, din}, {16'd0, mon_e.is_mem ? mem_q : mon_e.data});
                check("led", {22'd0, led}, {22'd0, mon_e.led});
                check("tmr_expired", {31'd0, exp_o}, {31'd0, mon_e.expd});
            end
        end
    end

    initial begin
        logic [7:0]  a;
        logic [15:0] d;
        int          c;
        model_reset();
        mem_q = 16'h5A5A;
        #12;
        check("rst_din", {16'd0, din}, 32'h5A5A);
        check("rst_led", {22'd0, led}, 32'h0);
        check("rst_exp", {31'd0, exp_o}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        step(8'h05, 16'h1234, 1'b1, sw);
        #1 check("mem_wren_low", {31'd0, mem_wren}, 32'h1);
        step(8'h80, 16'h1234, 1'b1, sw);
        #1 check("mem_wren_periph", {31'd0, mem_wren}, 32'h0);
        step(8'h80, 16'h0, 1'b0, sw);
        check("led_write", {22'd0, led}, 32'h234);

        step(8'h90, 16'h0, 1'b0, 10'h155);
        step(8'h90, 16'h0, 1'b0, 10'h155);
        step(8'h90, 16'h0, 1'b0, 10'h155);
        check("sw_not_yet", {16'd0, din}, 32'h0);
        step(8'h90, 16'h0, 1'b0, 10'h155);
        check("sw_sync", {16'd0, din}, 32'h155);

`ifdef MMIO_TIMER_EN
        step(8'hA0, 16'd3, 1'b1, sw);
        step(8'hA1, 16'h1, 1'b1, sw);
        e0 = edge_cnt + 1;
        for (int i = 0; i < 40 && !exp_o; i++) step(8'hA2, 16'h0, 1'b0, sw);
        check("oneshot_latency", edge_cnt - e0, 32'd12);
        step(8'hA1, 16'h0, 1'b0, sw);
        step(8'hA2, 16'h0, 1'b0, sw);
        check("ctrl_autoclear", {16'd0, din}, 32'h0);
        step(8'h00, 16'h0, 1'b0, sw);
        check("count_zero", {16'd0, din}, 32'h0);

        step(8'hA3, 16'h1, 1'b1, sw);
        step(8'hA0, 16'd2, 1'b1, sw);
        step(8'hA1, 16'h3, 1'b1, sw);
        for (int i = 1; i <= 7; i++) step(8'hA2, 16'h0, 1'b0, sw);
        step(8'hA3, 16'h1, 1'b1, sw);
        step(8'hA3, 16'h1, 1'b1, sw);
        check("w1c_set_wins", {31'd0, exp_o}, 32'h1);
        step(8'hA2, 16'h0, 1'b0, sw);
        check("w1c_clear", {31'd0, exp_o}, 32'h0);
        step(8'h00, 16'h0, 1'b0, sw);
        check("autoreload_count", {16'd0, din}, 32'h2);
        step(8'hA1, 16'h0, 1'b1, sw);
`else
        step(8'hA0, 16'd5, 1'b1, sw);
        step(8'hA1, 16'h1, 1'b1, sw);
        step(8'hA2, 16'h0, 1'b0, sw);
        step(8'h00, 16'h0, 1'b0, sw);
        check("a2_reads_zero", {16'd0, din}, 32'h0);
        check("no_timer_exp", {31'd0, exp_o}, 32'h0);
`endif

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 600; i++) begin
                c = $urandom_range(0, 9);
                a = c < 3 ? 8'($urandom_range(0, 127)) :
                    c < 5 ? (8'h80 | 8'($urandom_range(0, 15))) :
                    c == 5 ? (8'h90 | 8'($urandom_range(0, 15))) :
                    c < 9 ? (8'hA0 | 8'($urandom_range(0, 3))) : 8'($urandom_range(164, 255));
                d = (a[7:4] == 4'hA) ? 16'($urandom_range(0, 6)) : 16'($urandom);
                step(a, d, 1'($urandom), ($urandom_range(0, 7) == 0) ? 10'($urandom) : sw);
            end
            if (r == 0) begin
                step(8'h80, 16'h3FF, 1'b1, sw);
                step(8'hA0, 16'd5, 1'b1, sw);
                step(8'hA1, 16'h3, 1'b1, sw);
                repeat (10) step(8'hA2, 16'h0, 1'b0, sw);
                addr = '0; wdata = '0; w_en = 1'b0; sw = '0;
                #2 rst_n = 1'b0;
                mem_q = '0;
                #1;
                check("midrst_led", {22'd0, led}, 32'h0);
                check("midrst_din", {16'd0, din}, 32'h0);
                check("midrst_exp", {31'd0, exp_o}, 32'h0);
                q.delete();
                model_reset();
                repeat (2) @(posedge clk);
                @(negedge clk) rst_n = 1'b1;
                step(8'hA1, 16'h0, 1'b0, sw);
                step(8'hA2, 16'h0, 1'b0, sw);
                check("midrst_ctrl", {16'd0, din}, 32'h0);
            end
        end

        step(8'h00, 16'h0, 1'b0, sw);
        @(negedge clk);
        @(negedge clk);
        #1 check("scoreboard_drain", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
